// File: rtl/sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } sub_state_t;

    localparam int unsigned SUB_DEFAULT_WIDTH = 8;

endpackage : sub_pkg

// File: rtl/full_sub_cell.sv
// Full subtractor built from two half subtractors and a borrow OR.
module full_sub_cell (
    input  logic i_x,
    input  logic i_y,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    logic w_d1;
    logic w_b1;
    logic w_b2;

    half_sub_gate u_hs0 (
        .i_x    (i_x),
        .i_y    (i_y),
        .o_d    (w_d1),
        .o_bout (w_b1)
    );

    half_sub_gate u_hs1 (
        .i_x    (w_d1),
        .i_y    (i_bin),
        .o_d    (o_d),
        .o_bout (w_b2)
    );

    assign o_bout = w_b1 | w_b2;

endmodule : full_sub_cell

// File: rtl/half_sub_gate.sv
// Half subtractor: d = x - y, borrow when y > x.
module half_sub_gate (
    input  logic i_x,
    input  logic i_y,
    output logic o_d,
    output logic o_bout
);

    assign o_d    = i_x ^ i_y;
    assign o_bout = ~i_x & i_y;

endmodule : half_sub_gate

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock with start/done handshake.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    sub_state_t       r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_diff_sr;
    logic             r_borrow;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;

    logic             w_d;
    logic             w_bout;

    full_sub_cell u_cell (
        .i_x    (r_a_sr[0]),
        .i_y    (r_b_sr[0]),
        .i_bin  (r_borrow),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    // FSM, shift datapath and registered handshake/result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_a_sr       <= '0;
            r_b_sr       <= '0;
            r_diff_sr    <= '0;
            r_borrow     <= 1'b0;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a_sr    <= a;
                        r_b_sr    <= b;
                        r_diff_sr <= '0;
                        r_borrow  <= 1'b0;
                        r_count   <= '0;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_SHIFT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    r_a_sr    <= r_a_sr >> 1;
                    r_b_sr    <= r_b_sr >> 1;
                    r_diff_sr <= {w_d, r_diff_sr[WIDTH-1:1]};
                    r_borrow  <= w_bout;
                    r_count   <= r_count + CNT_W'(1);
                    // Last bit: publish the completed result as we enter DONE
                    if (r_count == CNT_W'(WIDTH - 1)) begin
                        r_state      <= S_DONE;
                        r_busy       <= 1'b0;
                        r_ready      <= 1'b1;
                        r_done       <= 1'b1;
                        r_diff       <= {w_d, r_diff_sr[WIDTH-1:1]};
                        r_borrow_out <= w_bout;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ready      = r_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): vector table, corner sequences, random ops.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int checks = 0;
    int errors = 0;
    int done_count = 0;

    logic [W:0] sb[$];
    logic [W:0] prev_res;
    logic       prev_rst = 1'b1;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] ediff;
        logic         eborrow;
    } vec_t;

    vec_t vecs[10];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: push on acceptance, pop on done; also watch result stability
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (done) begin
                done_count++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=%0h required=none", {borrow_out, diff});
                end else begin
                    chk("sb_result", 32'({borrow_out, diff}), 32'(sb.pop_front()));
                end
            end else if (!prev_rst) begin
                chk("result_stable", 32'({borrow_out, diff}), 32'(prev_res));
            end
            if (start && ready)
                sb.push_back({(a < b), W'(a - b)});
        end
        prev_rst = rst;
        prev_res = {borrow_out, diff};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [W-1:0] va, input logic [W-1:0] vb);
        int n = 0;
        while (!ready && n < 20) begin
            tick();
            n++;
        end
        if (!ready) chk("ready_timeout", 32'(ready), 32'd1);
        start = 1'b1;
        a = va;
        b = vb;
        tick();
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    task automatic wait_done(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 32'(seen), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_diff"}, 32'(diff), 32'd0);
        chk({tag, "_borrow"}, 32'(borrow_out), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int nbusy;
        int dc0;
        int last;

        vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[2] = '{8'hA7, 8'hA7, 8'h00, 1'b0};
        vecs[3] = '{8'h00, 8'hFF, 8'h01, 1'b1};
        vecs[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
        vecs[5] = '{8'h80, 8'h7F, 8'h01, 1'b0};
        vecs[6] = '{8'h7F, 8'h80, 8'hFF, 1'b1};
        vecs[7] = '{8'h03, 8'h05, 8'hFE, 1'b1};
        vecs[8] = '{8'h10, 8'h01, 8'h0F, 1'b0};
        vecs[9] = '{8'h01, 8'h02, 8'hFF, 1'b1};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_reset_outputs("reset");

        // Latency and busy duration
        start = 1'b1;
        a = 8'h5A;
        b = 8'h3C;
        nbusy = 0;
        cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1) begin
                start = 1'b0;
                a = 8'hFF;
                b = 8'hFF;
            end
            if (busy) nbusy++;
            if (done) begin
                cyc = c;
                break;
            end
        end
        chk("latency", 32'(cyc), 32'd9);
        chk("busy_cycles", 32'(nbusy), 32'd8);
        chk("lat_diff", 32'(diff), 32'h1E);
        tick();

        // Table-driven vectors
        foreach (vecs[i]) begin
            start_op(vecs[i].va, vecs[i].vb);
            wait_done(12);
            chk("vec_diff", 32'(diff), 32'(vecs[i].ediff));
            chk("vec_borrow", 32'(borrow_out), 32'(vecs[i].eborrow));
        end
        tick();

        // Start while busy is ignored
        dc0 = done_count;
        start_op(8'h10, 8'h01);
        tick();
        tick();
        start = 1'b1;
        a = 8'hFF;
        b = 8'h00;
        tick();
        start = 1'b0;
        wait_done(10);
        chk("ign_diff", 32'(diff), 32'h0F);
        chk("ign_borrow", 32'(borrow_out), 32'd0);
        repeat (12) tick();
        chk("ign_done_pulses", 32'(done_count - dc0), 32'd1);

        // Reset mid-operation aborts with no done
        start_op(8'h80, 8'h7F);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("abort");
        dc0 = done_count;
        repeat (12) tick();
        chk("abort_no_done", 32'(done_count - dc0), 32'd0);

        // Start held high: back-to-back every WIDTH+1 cycles
        start = 1'b1;
        a = 8'h03;
        b = 8'h05;
        last = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            chk("b2b_ready_eq_done", 32'(ready), 32'(done));
            if (done) begin
                chk("b2b_gap", 32'(c - last), 32'd9);
                chk("b2b_diff", 32'({borrow_out, diff}), 32'h1FE);
                last = c;
            end
        end
        start = 1'b0;
        wait_done(12);
        tick();

        // Random operations, occasionally back-to-back
        for (int i = 0; i < 1000; i++) begin
            start_op(W'($urandom), W'($urandom));
            wait_done(12);
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (12) tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_subtractor
